// File: rtl/ysyx_22050854_pkg.sv
// Shared constants, fetch-state encoding and IF/ID payload type for the
// ysyx_22050854 instruction fetch path.
package ysyx_22050854_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } ifu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } if_entry_t;

    // Sequential successor of a fetch address (32-bit wrap).
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INST_BYTES);
    endfunction

endpackage

// File: rtl/ysyx_22050854_if_skid.sv
// One-entry {pc, inst} holding buffer used when a response arrives while
// the IF/ID register cannot accept it.
module ysyx_22050854_if_skid
    import ysyx_22050854_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic        full,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out
);

    logic      full_q, full_d;
    if_entry_t entry_q, entry_d;

    // clear wins over load so a redirect never leaves a stale entry behind
    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (unload) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d  = 1'b1;
            entry_d = '{pc: pc_in, inst: inst_in};
        end
        if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign full     = full_q;
    assign pc_out   = entry_q.pc;
    assign inst_out = entry_q.inst;

endmodule

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: single-outstanding imem request sequencer that
// owns the fetch PC, drops redirect-stale responses and fills IF/ID.
module ysyx_22050854_ifu
    import ysyx_22050854_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ysyx_22050854_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = ysyx_22050854_pkg::NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        jump,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        IDreg_valid,
    output logic [31:0] IDreg_pc,
    output logic [31:0] IDreg_inst
);

    ifu_state_t  state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        drop_q, drop_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;

    logic        slot_free;
    logic        req_fire;
    logic        skid_load, skid_unload, skid_clear;
    logic        skid_full;
    logic [31:0] skid_pc, skid_inst;

    assign slot_free = ~id_valid_q | ~stall;
    assign req_fire  = req_valid_q & imem_req_ready;

    ysyx_22050854_if_skid u_skid (
        .clock    (clock),
        .reset    (reset),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .pc_in    (fpc_q),
        .inst_in  (imem_resp_data),
        .full     (skid_full),
        .pc_out   (skid_pc),
        .inst_out (skid_inst)
    );

    // Next-state, fetch PC, drop flag and IF/ID update
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        drop_d      = drop_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (id_valid_q && !stall) begin
            id_valid_d = 1'b0;
        end

        if (jump) begin
            fpc_d      = next_pc;
            id_valid_d = 1'b0;
            skid_clear = 1'b1;
            case (state_q)
                // an unaccepted request stays on the bus until taken, its reply is dropped
                ST_REQ: begin
                    drop_d = 1'b1;
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (slot_free) begin
                            id_valid_d = 1'b1;
                            id_pc_d    = fpc_q;
                            id_inst_d  = imem_resp_data;
                            fpc_d      = seq_pc(fpc_q);
                            state_d    = ST_REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (slot_free && skid_full) begin
                        id_valid_d  = 1'b1;
                        id_pc_d     = skid_pc;
                        id_inst_d   = skid_inst;
                        skid_unload = 1'b1;
                        fpc_d       = seq_pc(fpc_q);
                        state_d     = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (!id_valid_d) begin
            id_inst_d = NOP_INST;
        end
    end

    // Request address is latched only on entry to REQ so it stays put until accepted
    always_comb begin
        req_valid_d = (state_d == ST_REQ);
        req_addr_d  = req_addr_q;
        if (state_d == ST_REQ && state_q != ST_REQ) begin
            req_addr_d = fpc_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fpc_q       <= RESET_PC;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'h0;
            id_inst_q   <= NOP_INST;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign IDreg_valid    = id_valid_q;
    assign IDreg_pc       = id_pc_q;
    assign IDreg_inst     = id_inst_q;

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Bench for ysyx_22050854_ifu: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level fetch model.
module tb_ysyx_22050854_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [31:0] next_pc;
    logic        jump;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        IDreg_valid;
    logic [31:0] IDreg_pc;
    logic [31:0] IDreg_inst;

    ysyx_22050854_ifu #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .next_pc         (next_pc),
        .jump            (jump),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .IDreg_valid     (IDreg_valid),
        .IDreg_pc        (IDreg_pc),
        .IDreg_inst      (IDreg_inst)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Transaction-level model: where the fetcher is in its request/response life cycle
    bit          m_boot, m_present, m_await, m_stale;
    logic [31:0] m_fpc, m_addr;
    bit          m_idv;
    logic [31:0] m_idpc, m_idinst;
    logic [63:0] m_skid[$];

    // Memory / stimulus knobs and state
    int          k_rdy_pct = 100;
    int          k_lat     = 1;
    bit          k_spur    = 1'b0;
    bit          k_stall   = 1'b0;
    bit          k_jump    = 1'b0;
    logic [31:0] k_npc     = 32'h0;
    bit          mem_busy  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_addr  = 32'h0;
    bit          resp_now  = 1'b0;
    logic [31:0] acc_q[$];

    task automatic model_reset();
        m_boot    = 1'b1;
        m_present = 1'b0;
        m_await   = 1'b0;
        m_stale   = 1'b0;
        m_fpc     = RST_PC;
        m_addr    = RST_PC;
        m_idv     = 1'b0;
        m_idpc    = 32'h0;
        m_idinst  = NOP;
        m_skid.delete();
    endtask

    task automatic model_load(input logic [31:0] pc, input logic [31:0] inst);
        m_idv    = 1'b1;
        m_idpc   = pc;
        m_idinst = inst;
        m_fpc    = pc + 32'd4;
        m_present = 1'b1;
        m_addr   = m_fpc;
    endtask

    task automatic model_step();
        bit free, hs, was_boot, was_present, was_await, was_stale;
        logic [63:0] e;
        free        = !m_idv || !stall;
        hs          = m_present && imem_req_ready;
        was_boot    = m_boot;
        was_present = m_present;
        was_await   = m_await;
        was_stale   = m_stale;
        if (m_idv && !stall) m_idv = 1'b0;
        if (jump) begin
            m_fpc = next_pc;
            m_idv = 1'b0;
            m_skid.delete();
            if (was_present) begin
                m_stale = 1'b1;
                if (hs) begin
                    m_present = 1'b0;
                    m_await   = 1'b1;
                end
            end else if (was_await && !imem_resp_valid) begin
                m_stale = 1'b1;
            end else begin
                m_boot    = 1'b0;
                m_await   = 1'b0;
                m_stale   = 1'b0;
                m_present = 1'b1;
                m_addr    = next_pc;
            end
        end else if (was_boot) begin
            m_boot    = 1'b0;
            m_present = 1'b1;
            m_addr    = m_fpc;
        end else if (was_present) begin
            if (hs) begin
                m_present = 1'b0;
                m_await   = 1'b1;
            end
        end else if (was_await) begin
            if (imem_resp_valid) begin
                m_await = 1'b0;
                if (was_stale) begin
                    m_stale   = 1'b0;
                    m_present = 1'b1;
                    m_addr    = m_fpc;
                end else if (free) begin
                    model_load(m_fpc, imem_resp_data);
                end else begin
                    m_skid.push_back({m_fpc, imem_resp_data});
                end
            end
        end else if (m_skid.size() != 0 && free) begin
            e = m_skid.pop_front();
            model_load(e[63:32], e[31:0]);
        end
        if (!m_idv) m_idinst = NOP;
    endtask

    task automatic check_model();
        check_eq("req_valid", 32'(imem_req_valid), 32'(m_present));
        if (m_present || !reset) check_eq("req_addr", imem_req_addr, m_addr);
        check_eq("id_valid", 32'(IDreg_valid), 32'(m_idv));
        if (m_idv || !reset) check_eq("id_pc", IDreg_pc, m_idpc);
        check_eq("id_inst", IDreg_inst, m_idinst);
    endtask

    task automatic drive_inputs();
        stall   = k_stall;
        jump    = k_jump;
        next_pc = k_npc;
        resp_now = mem_busy && (mem_cnt == 0);
        if (resp_now) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
        end else begin
            imem_resp_valid = k_spur && !mem_busy && ($urandom_range(0, 7) == 0);
            imem_resp_data  = $urandom;
        end
        imem_req_ready = reset && !mem_busy && (int'($urandom_range(0, 99)) < k_rdy_pct);
    endtask

    task automatic update_mem();
        if (resp_now) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (reset && imem_req_valid && imem_req_ready) begin
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = (k_lat == 0) ? int'($urandom_range(0, 2)) : k_lat - 1;
            acc_q.push_back(imem_req_addr);
        end
    endtask

    task automatic step();
        @(negedge clock);
        reset = 1'b1;
        drive_inputs();
        #1;
        model_step();
        update_mem();
        @(posedge clock);
        #1;
        check_model();
        k_jump = 1'b0;
    endtask

    // Reset stays low for n cycles; the memory keeps running so late replies land here
    task automatic reset_phase(input int n);
        @(negedge clock);
        reset = 1'b0;
        drive_inputs();
        stall = 1'b0;
        jump  = 1'b0;
        #1;
        model_reset();
        check_model();
        update_mem();
        for (int i = 1; i < n; i++) begin
            @(negedge clock);
            drive_inputs();
            stall = 1'b0;
            jump  = 1'b0;
            #1;
            update_mem();
            @(posedge clock);
            #1;
            check_model();
        end
    endtask

    initial begin
        reset           = 1'b0;
        stall           = 1'b0;
        jump            = 1'b0;
        next_pc         = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        model_reset();

        reset_phase(3);

        // in-order fetch, ready always high, one-cycle memory
        repeat (9) step();
        check_eq("seq_addr0", acc_q[0], 32'h8000_0000);
        check_eq("seq_addr1", acc_q[1], 32'h8000_0004);
        check_eq("seq_addr2", acc_q[2], 32'h8000_0008);
        check_eq("seq_id_pc", IDreg_pc, 32'h8000_000C);
        check_eq("seq_id_valid", 32'(IDreg_valid), 32'd1);

        // stall with IF/ID full: reply parks in the skid, no further request
        k_stall = 1'b1;
        repeat (5) step();
        check_eq("stall_no_req", 32'(imem_req_valid), 32'd0);
        check_eq("stall_id_pc", IDreg_pc, 32'h8000_000C);
        check_eq("stall_id_inst", IDreg_inst, mem_word(32'h8000_000C));
        check_eq("stall_acc_cnt", 32'(acc_q.size()), 32'd5);
        k_stall = 1'b0;
        step();
        check_eq("skid_id_pc", IDreg_pc, 32'h8000_0010);
        check_eq("skid_id_inst", IDreg_inst, mem_word(32'h8000_0010));
        check_eq("skid_next_addr", imem_req_addr, 32'h8000_0014);

        // redirect while waiting, stale reply two cycles later
        k_lat = 3;
        step();
        k_jump = 1'b1;
        k_npc  = 32'h8000_0100;
        step();
        check_eq("jwait_id_valid", 32'(IDreg_valid), 32'd0);
        step();
        check_eq("jwait_no_req", 32'(imem_req_valid), 32'd0);
        step();
        check_eq("jwait_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("jwait_req_addr", imem_req_addr, 32'h8000_0100);

        // redirect in the same cycle as the reply
        k_lat = 1;
        step();
        k_jump = 1'b1;
        k_npc  = 32'h8000_0100;
        step();
        check_eq("jresp_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("jresp_req_addr", imem_req_addr, 32'h8000_0100);
        check_eq("jresp_id_valid", 32'(IDreg_valid), 32'd0);

        // ready low for three cycles: address held, exactly one acceptance
        k_rdy_pct = 0;
        repeat (3) begin
            step();
            check_eq("bp_req_addr", imem_req_addr, 32'h8000_0100);
        end
        k_rdy_pct = 100;
        k_lat     = 3;
        step();
        check_eq("bp_acc_cnt", 32'(acc_q.size()), 32'd8);
        check_eq("bp_acc_addr", acc_q[7], 32'h8000_0100);
        step();

        // reset while waiting; the reply lands during reset and must be ignored
        reset_phase(3);
        k_lat = 1;
        repeat (3) step();
        check_eq("rst_restart_addr", acc_q[8], 32'h8000_0000);
        check_eq("rst_id_pc", IDreg_pc, 32'h8000_0000);
        check_eq("rst_id_valid", 32'(IDreg_valid), 32'd1);

        // randomized traffic with spurious replies, redirects and occasional reset
        k_spur    = 1'b1;
        k_lat     = 0;
        k_rdy_pct = 60;
        for (int i = 0; i < 4000; i++) begin
            k_stall = ($urandom_range(0, 3) == 0);
            k_jump  = ($urandom_range(0, 11) == 0);
            k_npc   = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 399) == 0) begin
                k_jump = 1'b0;
                reset_phase(2);
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
